// File: rtl/color_scan_ctrl.sv
// -----------------------------------------------------------------------------
// color_scan_ctrl
//
// Controls a light-to-frequency colour sensor. One scan visits the red, green
// and blue filters in turn. For each filter it waits a settling time and then
// counts rising edges of the sensor output over a fixed window. When all three
// counts are in, it publishes them together with the strongest channel.
//
// Parameters
//   CNT_W         width of each per-channel edge count (saturating)
//   WIN_W         width of the window_cycles configuration input
//
// Ports
//   clk           system clock; all state changes on the rising edge
//   rst           synchronous, active-high reset
//   start         request a full R/G/B scan; only acted on while idle
//   freq_in       asynchronous sensor frequency output
//   window_cycles count window per channel in clk cycles (0 behaves as 1)
//   settle_cycles filter settling time per channel in clk cycles (0 behaves as 1)
//   filter_select sensor filter code: 00 red, 11 green, 10 blue, 01 clear
//   busy          high whenever a scan is in progress (including DONE)
//   done          one-cycle pulse when a scan completes
//   red/green/blue published edge counts of the last completed scan
//   dominant      strongest channel: 00 R, 01 G, 10 B, 11 none (all zero)
// -----------------------------------------------------------------------------
module color_scan_ctrl #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned WIN_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             freq_in,
  input  logic [WIN_W-1:0] window_cycles,
  input  logic [15:0]      settle_cycles,
  output logic [1:0]       filter_select,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] red,
  output logic [CNT_W-1:0] green,
  output logic [CNT_W-1:0] blue,
  output logic [1:0]       dominant
);

  // Phase counter covers both the window and the settle time without overflow.
  localparam int unsigned PH_W = (WIN_W > 16) ? WIN_W : 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_DONE
  } state_e;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  state_e           state_q, state_d;
  logic [1:0]       ch_q, ch_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PH_W-1:0]  win_q, win_d;
  logic [PH_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shadow_r_q, shadow_r_d;
  logic [CNT_W-1:0] shadow_g_q, shadow_g_d;
  logic [CNT_W-1:0] shadow_b_q, shadow_b_d;
  logic [CNT_W-1:0] red_q, red_d;
  logic [CNT_W-1:0] green_q, green_d;
  logic [CNT_W-1:0] blue_q, blue_d;
  logic [1:0]       dominant_q, dominant_d;

  logic sync1_q, sync2_q, prev_q, edge_q;

  logic [PH_W-1:0]  win_eff, settle_eff;
  logic [CNT_W-1:0] cnt_inc;

  // Strict maximum wins; ties go R over G over B; all-zero reports "none".
  function automatic logic [1:0] pick_dominant(input logic [CNT_W-1:0] r,
                                               input logic [CNT_W-1:0] g,
                                               input logic [CNT_W-1:0] b);
    if (r == '0 && g == '0 && b == '0) return 2'b11;
    if (r >= g && r >= b)              return 2'b00;
    if (g >= b)                        return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [1:0] filter_code(input logic [1:0] ch);
    case (ch)
      CH_R:    return 2'b00;
      CH_G:    return 2'b11;
      CH_B:    return 2'b10;
      default: return 2'b01;
    endcase
  endfunction

  // A configured length of zero runs as a one-cycle phase.
  assign win_eff    = (window_cycles == '0) ? PH_W'(1) : PH_W'(window_cycles);
  assign settle_eff = (settle_cycles == '0) ? PH_W'(1) : PH_W'(settle_cycles);

  // Working count including this cycle's edge, held at full scale.
  assign cnt_inc = (edge_q && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;

  // NOTE: every signal written here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    phase_d    = phase_q;
    win_d      = win_q;
    settle_d   = settle_q;
    cnt_d      = cnt_q;
    shadow_r_d = shadow_r_q;
    shadow_g_d = shadow_g_q;
    shadow_b_d = shadow_b_q;
    red_d      = red_q;
    green_d    = green_q;
    blue_d     = blue_q;
    dominant_d = dominant_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          win_d    = win_eff;
          settle_d = settle_eff;
          ch_d     = CH_R;
          phase_d  = settle_eff - PH_W'(1);
          state_d  = S_SETTLE;
        end
      end

      // phase_q counts down to zero, so each phase lasts exactly its length.
      S_SETTLE: begin
        if (phase_q == '0) begin
          cnt_d   = '0;
          phase_d = win_q - PH_W'(1);
          state_d = S_COUNT;
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end

      S_COUNT: begin
        cnt_d = cnt_inc;
        if (phase_q == '0) begin
          unique case (ch_q)
            CH_R:    shadow_r_d = cnt_inc;
            CH_G:    shadow_g_d = cnt_inc;
            default: shadow_b_d = cnt_inc;
          endcase
          if (ch_q == CH_B) begin
            // Publish on the way into DONE so the results are already valid
            // while done is high. Blue's shadow is being written on this same
            // edge, so its value is taken from the count directly.
            red_d      = shadow_r_q;
            green_d    = shadow_g_q;
            blue_d     = cnt_inc;
            dominant_d = pick_dominant(shadow_r_q, shadow_g_q, cnt_inc);
            state_d    = S_DONE;
          end else begin
            ch_d    = ch_q + 2'd1;
            phase_d = settle_q - PH_W'(1);
            state_d = S_SETTLE;
          end
        end else begin
          phase_d = phase_q - PH_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they stood before the edge (the synchronizer chain
  // below depends on this to act as a real shift register).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ch_q       <= CH_R;
      phase_q    <= '0;
      win_q      <= '0;
      settle_q   <= '0;
      cnt_q      <= '0;
      shadow_r_q <= '0;
      shadow_g_q <= '0;
      shadow_b_q <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      dominant_q <= 2'b11;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      edge_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      phase_q    <= phase_d;
      win_q      <= win_d;
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      shadow_r_q <= shadow_r_d;
      shadow_g_q <= shadow_g_d;
      shadow_b_q <= shadow_b_d;
      red_q      <= red_d;
      green_q    <= green_d;
      blue_q     <= blue_d;
      dominant_q <= dominant_d;
      // Two-flop synchronizer, then a registered rising-edge detector.
      sync1_q    <= freq_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      edge_q     <= sync2_q & ~prev_q;
    end
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    filter_select = 2'b01;
    if (state_q == S_SETTLE || state_q == S_COUNT) filter_select = filter_code(ch_q);
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign dominant = dominant_q;

endmodule

// File: tb/tb_color_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_color_scan_ctrl
//
// Directed bench for color_scan_ctrl. A sensor model drives freq_in as a
// square wave whose period depends on the filter currently selected. A
// scan-level model predicts busy/done/filter_select from the scan timeline
// (settle + window per channel) and the published counts from window/period,
// and one compare process checks the DUT against it on every cycle. Count
// width is reduced to 8 bits so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_color_scan_ctrl;

  localparam int CNT_W   = 8;
  localparam int WIN_W   = 32;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             freq_in;
  logic [WIN_W-1:0] window_cycles;
  logic [15:0]      settle_cycles;
  logic [1:0]       filter_select;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] red, green, blue;
  logic [1:0]       dominant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  color_scan_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .freq_in       (freq_in),
    .window_cycles (window_cycles),
    .settle_cycles (settle_cycles),
    .filter_select (filter_select),
    .busy          (busy),
    .done          (done),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .dominant      (dominant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_tol(input string name, input logic [31:0] act, input int exp, input int tol);
    int d;
    n_cmp++;
    d = int'(act) - exp;
    if (d < 0) d = -d;
    if ($isunknown(act) || d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, act, exp, tol, $time);
    end
  endtask

  // ---------------------------------------------------------------- sensor
  // per[] is indexed by filter code: 00 red, 11 green, 10 blue, 01 clear.
  // A period of 0 holds freq_in low.
  int per[4];
  int ph = 0;

  always @(negedge clk) begin
    int p;
    p = $isunknown(filter_select) ? 0 : per[filter_select];
    ph++;
    freq_in = (p > 0) && ((ph % p) < (p / 2));
  end

  task automatic set_per(input int r, input int g, input int b);
    per[0] = r;
    per[1] = r;
    per[3] = g;
    per[2] = b;
  endtask

  // ----------------------------------------------------------------- model
  function automatic int exp_count(input int p, input int w);
    int c;
    if (p == 0) return 0;
    c = w / p;
    return (c > CNT_MAX) ? CNT_MAX : c;
  endfunction

  function automatic logic [1:0] dom_of(input int r, input int g, input int b);
    int m;
    m = r;
    if (g > m) m = g;
    if (b > m) m = b;
    if (m == 0) return 2'b11;
    if (r == m) return 2'b00;
    if (g == m) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [1:0] code_of(input int ch);
    if (ch == 0) return 2'b00;
    if (ch == 1) return 2'b11;
    return 2'b10;
  endfunction

  bit         chk_en = 1'b0;
  int         tol = 0;          // count tolerance for the next scan started
  int         edge_n = 0;
  int         acc_edge = 0;
  bit         m_act = 1'b0;
  int         m_t = 0;          // cycles since the accepting edge
  int         m_s = 1;
  int         m_w = 1;
  int         m_exp[3];
  int         m_scan_tol = 0;
  int         m_red = 0, m_grn = 0, m_blu = 0, m_out_tol = 0;
  logic [1:0] m_dom = 2'b11;

  always @(posedge clk) begin
    edge_n++;
    if (rst) begin
      m_act = 1'b0;
      m_red = 0; m_grn = 0; m_blu = 0; m_out_tol = 0;
      m_dom = 2'b11;
    end else if (m_act) begin
      m_t++;
      if (m_t == 3 * (m_s + m_w)) begin
        m_red = m_exp[0]; m_grn = m_exp[1]; m_blu = m_exp[2];
        m_out_tol = m_scan_tol;
        m_dom = dom_of(m_exp[0], m_exp[1], m_exp[2]);
      end else if (m_t > 3 * (m_s + m_w)) begin
        m_act = 1'b0;
      end
    end else if (start) begin
      m_act = 1'b1;
      m_t = 0;
      acc_edge = edge_n;
      m_s = (settle_cycles == 0) ? 1 : int'(settle_cycles);
      m_w = (window_cycles == 0) ? 1 : int'(window_cycles);
      m_exp[0] = exp_count(per[0], m_w);
      m_exp[1] = exp_count(per[3], m_w);
      m_exp[2] = exp_count(per[2], m_w);
      m_scan_tol = tol;
    end
  end

  function automatic int tol_for(input int v, input int t);
    return (v == 0 || v >= CNT_MAX) ? 0 : t;
  endfunction

  // --------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_act);
      check("done", done, m_act && m_t == 3 * (m_s + m_w));
      if (!m_act)
        check("filter_idle", filter_select, 2'b01);
      else if (m_t < 3 * (m_s + m_w))
        check("filter_scan", filter_select, code_of(m_t / (m_s + m_w)));
      check_tol("red", red, m_red, tol_for(m_red, m_out_tol));
      check_tol("green", green, m_grn, tol_for(m_grn, m_out_tol));
      check_tol("blue", blue, m_blu, tol_for(m_blu, m_out_tol));
      check("dominant", dominant, m_dom);
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic run_scan(input int w, input int s);
    window_cycles = w;
    settle_cycles = s[15:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    for (int i = 0; i < max_cyc && done !== 1'b1; i++) @(negedge clk);
    check("done_seen", done, 1'b1);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc && busy !== 1'b0; i++) @(negedge clk);
    check("idle_seen", busy, 1'b0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1;
    start = 1'b0;
    window_cycles = 100;
    settle_cycles = 5;
    set_per(0, 0, 0);
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_dominant", dominant, 2'b11);
    check("rst_filter", filter_select, 2'b01);
    check("rst_red", red, 0);
    rst = 1'b0;
    @(negedge clk);

    // Nominal: period 10 everywhere, settle 5, window 100.
    set_per(10, 10, 10);
    tol = 0;
    run_scan(100, 5);
    wait_done(400);
    check("nom_latency", edge_n - acc_edge, 315);
    check("nom_red", red, 10);
    check("nom_green", green, 10);
    check("nom_blue", blue, 10);
    check("nom_dominant", dominant, 2'b00);
    @(negedge clk);

    // Distinct rates: R 40, G 10, B 20, window 400, settle 3.
    set_per(40, 10, 20);
    tol = 1;
    run_scan(400, 3);
    wait_done(1300);
    check_tol("dist_red", red, 10, 1);
    check_tol("dist_green", green, 40, 1);
    check_tol("dist_blue", blue, 20, 1);
    check("dist_dominant", dominant, 2'b01);
    @(negedge clk);

    // Reset during the green count window, with start held alongside it.
    set_per(10, 10, 10);
    tol = 0;
    run_scan(20, 2);
    repeat (26) @(negedge clk);
    check("pre_rst_filter", filter_select, 2'b11);
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_dominant", dominant, 2'b11);
    check("mid_rst_green", green, 0);
    rst = 1'b0;
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("mid_rst_no_done", pulses, 0);

    // Saturation: freq_in toggles every clk, 300 edges per window.
    set_per(2, 2, 2);
    run_scan(600, 4);
    wait_done(2000);
    check("sat_red", red, CNT_MAX);
    check("sat_green", green, CNT_MAX);
    check("sat_blue", blue, CNT_MAX);
    check("sat_dominant", dominant, 2'b00);
    @(negedge clk);

    // Zero config; a start pulse and a window change inside the scan.
    set_per(0, 0, 0);
    run_scan(0, 0);
    @(negedge clk);
    start = 1'b1;
    window_cycles = 9;
    @(negedge clk);
    start = 1'b0;
    wait_done(20);
    check("zero_latency", edge_n - acc_edge, 6);
    check("zero_dominant", dominant, 2'b11);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("zero_single_done", pulses, 0);

    // Idle sensor: freq_in low, window 50.
    run_scan(50, 5);
    wait_done(200);
    check("idle_red", red, 0);
    check("idle_dominant", dominant, 2'b11);
    @(negedge clk);

    // Start held high: back-to-back scans, one idle cycle between them.
    window_cycles = 1;
    settle_cycles = 1;
    start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    start = 1'b0;
    check("held_start_dones", pulses, 3);
    wait_idle(20);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
